// File: rtl/apu_pwm_decoder.sv
// apu_pwm_decoder: recovers the 8-bit mixed sample from a high-first 1-bit
// PWM stream (high for N cycles, then low, in each PERIOD-cycle frame).
// Locks onto the frame phase at a rising edge, counts high cycles per frame,
// and presents each result through a valid/ready output register.
// Optional macro APU_PWM_DEC_AVG_EN: output the 4-frame moving average
// instead of the raw per-frame count.
module apu_pwm_decoder #(
  parameter int unsigned PERIOD      = 256,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ERR_LIMIT   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [7:0] sample_out,
  output logic       sample_valid,
  input  logic       sample_ready,
  output logic       locked,
  output logic       overrun,
  output logic [7:0] err_count
);

  localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned CW = $clog2(ERR_LIMIT + 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s, s_d, rise;
  logic [PW-1:0]          phase_cnt;
  logic [8:0]             high_acc;
  logic [8:0]             acc_sum;
  logic [7:0]             result;
  logic [CW-1:0]          err_run;
  logic                   phase_err, frame_done, err_trip;
  logic                   load;
  logic [7:0]             load_val;

  // Input synchronizer plus one-cycle delay for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      s_d  <= s;
    end
  end

  assign s       = sync[SYNC_STAGES-1];
  assign rise    = s & ~s_d;
  assign acc_sum = high_acc + {8'd0, s};
  assign result  = acc_sum[8] ? 8'hFF : acc_sum[7:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_next;
  end

  // Next-state logic and per-cycle frame events
  always_comb begin
    state_next = state;
    phase_err  = 1'b0;
    frame_done = 1'b0;
    err_trip   = 1'b0;
    case (state)
      HUNT: begin
        if (rise) state_next = LOCKED;
      end
      LOCKED: begin
        phase_err  = rise && (phase_cnt != '0);
        frame_done = !phase_err && (phase_cnt == PW'(PERIOD - 1));
        err_trip   = phase_err && (err_run == CW'(ERR_LIMIT - 1));
        if (err_trip) state_next = HUNT;
      end
      default: state_next = HUNT;
    endcase
  end

  // Output decode
  always_comb begin
    locked = (state == LOCKED);
  end

  // Frame phase counter, high-cycle accumulator and error counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_cnt <= '0;
      high_acc  <= '0;
      err_run   <= '0;
      err_count <= '0;
    end else if (state == HUNT) begin
      // The acquiring edge is phase 0 and counts as a high cycle
      phase_cnt <= rise ? PW'(1) : '0;
      high_acc  <= rise ? 9'd1 : 9'd0;
    end else if (phase_err) begin
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (err_trip) begin
        err_run   <= '0;
        phase_cnt <= '0;
        high_acc  <= '0;
      end else begin
        err_run   <= err_run + CW'(1);
        phase_cnt <= PW'(1);
        high_acc  <= 9'd1;
      end
    end else if (frame_done) begin
      phase_cnt <= '0;
      high_acc  <= '0;
      err_run   <= '0;
    end else begin
      phase_cnt <= phase_cnt + PW'(1);
      high_acc  <= acc_sum;
    end
  end

`ifdef APU_PWM_DEC_AVG_EN
  logic [7:0] hist [4];
  logic [9:0] avg_sum, avg_sum_next;
  logic [2:0] fill;

  // Sum is updated in the same cycle the result arrives, so the average
  // adds no latency beyond the output load
  assign avg_sum_next = avg_sum + 10'(result) - 10'(hist[3]);
  assign load         = frame_done && (fill >= 3'd3);
  assign load_val     = avg_sum_next[9:2];

  // Result history; cleared on reset and whenever lock is lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) hist[i] <= '0;
      avg_sum <= '0;
      fill    <= '0;
    end else if (err_trip) begin
      for (int unsigned i = 0; i < 4; i++) hist[i] <= '0;
      avg_sum <= '0;
      fill    <= '0;
    end else if (frame_done) begin
      hist[0] <= result;
      for (int unsigned i = 1; i < 4; i++) hist[i] <= hist[i-1];
      avg_sum <= avg_sum_next;
      if (fill != 3'd4) fill <= fill + 3'd1;
    end
  end
`else
  assign load     = frame_done;
  assign load_val = result;
`endif

  // Output register with valid/ready handshake and sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (load) begin
      sample_out   <= load_val;
      sample_valid <= 1'b1;
      if (sample_valid && !sample_ready) overrun <= 1'b1;
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apu_pwm_decoder.sv
// Self-checking bench for apu_pwm_decoder: table-driven frames, randomized
// frames against a duty-cycle reference model, and hand-written sequences
// for phase errors, lock loss, backpressure and mid-frame reset.
module tb_apu_pwm_decoder;

  localparam int PERIOD = 256;
  localparam int SYNC   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwm_in;
  logic [7:0] sample_out;
  logic       sample_valid;
  logic       sample_ready;
  logic       locked;
  logic       overrun;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct {
    int value;
    int exp_v;
  } vec_t;

  vec_t vec[7];

  apu_pwm_decoder #(
    .PERIOD(PERIOD),
    .SYNC_STAGES(SYNC),
    .ERR_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pwm_in(pwm_in),
    .sample_out(sample_out),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .locked(locked),
    .overrun(overrun),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endfunction

  // Reference: a frame's sample is its high-cycle count, saturated at 255
  function automatic int ref_sample(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Pin-level driver: high for hi cycles then low, total cycles long
  task automatic drive_bits(input int hi, input int total);
    for (int i = 0; i < total; i++) begin
      pwm_in = (i < hi);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_frame(input int v, input int e);
    if (e >= 0) exp_q.push_back(e);
    drive_bits(v, PERIOD);
  endtask

  // Every accepted sample must match the next expected value
  always @(negedge clk) begin
    if (!rst && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample: got %0d, required no sample", sample_out);
      end else begin
        chk("sample_out", int'(sample_out), exp_q.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_sample_out"}, int'(sample_out), 0);
    chk({tag, "_sample_valid"}, int'(sample_valid), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
    chk({tag, "_err_count"}, int'(err_count), 0);
  endtask

  initial begin
    rst          = 1'b1;
    pwm_in       = 1'b0;
    sample_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    drive_bits(0, 5);
    chk("hunt_locked", int'(locked), 0);

`ifdef APU_PWM_DEC_AVG_EN
    begin
      int hist[$];
      for (int i = 1; i <= 5; i++) begin
        int sum;
        hist.push_back(10 * i);
        if (hist.size() > 4) void'(hist.pop_front());
        sum = 0;
        foreach (hist[k]) sum += hist[k];
        drive_frame(10 * i, (hist.size() == 4) ? sum / 4 : -1);
      end
      drive_bits(0, 20);
      chk("avg_locked", int'(locked), 1);
      chk("avg_err_count", int'(err_count), 0);
    end
`else
    vec[0] = '{100, 100};
    vec[1] = '{100, 100};
    vec[2] = '{0, 0};
    vec[3] = '{1, 1};
    vec[4] = '{255, 255};
    vec[5] = '{256, 255};
    vec[6] = '{100, 100};

    // Table of frames, with a lock check shortly after the first edge
    fork
      for (int i = 0; i < 7; i++) drive_frame(vec[i].value, vec[i].exp_v);
      begin
        repeat (SYNC + 3) @(posedge clk);
        #1;
        chk("locked_first_edge", int'(locked), 1);
      end
    join

    // Randomized contiguous frames
    for (int i = 0; i < 24; i++) begin
      int v;
      v = int'($urandom_range(0, 256));
      drive_frame(v, ref_sample(v));
    end
    chk("steady_err_count", int'(err_count), 0);
    chk("steady_locked", int'(locked), 1);
    chk("steady_overrun", int'(overrun), 0);

    // Single phase error: edge at phase 37 discards the frame
    drive_bits(20, 37);
    drive_frame(70, 70);
    chk("phase_err_count", int'(err_count), 1);
    chk("phase_err_locked", int'(locked), 1);

    // Five 37-cycle frames: first edge on time, next four are errors
    for (int i = 0; i < 5; i++) drive_bits(10, 37);
    chk("lock_loss_locked", int'(locked), 0);
    chk("lock_loss_err_count", int'(err_count), 5);
    drive_frame(90, 90);
    chk("relock_locked", int'(locked), 1);
    chk("relock_err_count", int'(err_count), 5);

    // Backpressure across two frames
    fork
      begin
        drive_frame(50, -1);
        drive_frame(60, 60);
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        sample_ready = 1'b0;
        repeat (PERIOD + 12) @(posedge clk);
        #1;
        chk("bp_hold_valid", int'(sample_valid), 1);
        chk("bp_hold_out", int'(sample_out), 50);
        chk("bp_hold_overrun", int'(overrun), 0);
      end
    join

    // Frame 200 starts; drain the backpressured sample, then reset at phase 120
    fork
      drive_bits(200, 120);
      begin
        repeat (SYNC + 4) @(posedge clk);
        #1;
        chk("bp_valid", int'(sample_valid), 1);
        chk("bp_out", int'(sample_out), 60);
        chk("bp_overrun", int'(overrun), 1);
        sample_ready = 1'b1;
        @(posedge clk);
        #1;
        sample_ready = 1'b0;
        chk("bp_accept_valid", int'(sample_valid), 0);
        chk("bp_accept_overrun", int'(overrun), 1);
      end
    join

    rst = 1'b1;
    #1;
    check_all_zero("midframe_reset");
    drive_bits(80, 90);
    rst          = 1'b0;
    sample_ready = 1'b1;
    drive_bits(0, 46);
    drive_frame(200, 200);
    drive_bits(0, 20);
    chk("post_reset_err_count", int'(err_count), 0);
    chk("post_reset_locked", int'(locked), 1);
    chk("post_reset_overrun", int'(overrun), 0);
`endif

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
